// File: rtl/rv32i_hazard_ctrl.sv
// Hazard sequencer for the rv32i 5-stage pipeline: load-use stalls,
// jump/branch squash, EBREAK halt/resume and saturating debug counters.
module rv32i_hazard_ctrl #(
    parameter int LOAD_USE_STALL = 1,
    parameter int FLUSH_DEPTH    = 1,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      id_iw,
    input  logic [31:0]      ex_iw,
    input  logic             jump_en,
    input  logic             halt_clr,
    output logic             if_stall,
    output logic             id_stall,
    output logic             ex_bubble,
    output logic             if_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int MAXV = (LOAD_USE_STALL > FLUSH_DEPTH) ?
                          LOAD_USE_STALL : FLUSH_DEPTH;
    localparam int DW = (MAXV > 0) ? $clog2(MAXV + 1) : 1;
    localparam logic [DW-1:0] LU_LD = DW'(LOAD_USE_STALL - 1);
    localparam logic [DW-1:0] FL_LD = DW'(FLUSH_DEPTH - 1);
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {RUN, STALL, FLUSH, HALT} state_e;

    state_e           state_q, state_d;
    logic [DW-1:0]    cnt_q, cnt_d;
    logic             skip_q, skip_d;
    logic [31:0]      prev_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [6:0] ex_op, id_op;
    logic [4:0] rd;
    logic       rs1_use, rs2_use;
    logic       lu_hit, ebrk;
    logic       stall, flush;

    always_comb begin
        ex_op   = ex_iw[6:0];
        id_op   = id_iw[6:0];
        rd      = ex_iw[11:7];
        rs1_use = !(id_op inside {7'b0110111, 7'b0010111, 7'b1101111});
        rs2_use = id_op inside {7'b0110011, 7'b0100011, 7'b1100011};
        lu_hit  = (ex_op == 7'b0000011) && (rd != 5'd0) &&
                  (((rd == id_iw[19:15]) && rs1_use) ||
                   ((rd == id_iw[24:20]) && rs2_use));
        // A resumed EBREAK stays masked until ID sees a different word.
        ebrk    = (id_iw == EBREAK) && !(skip_q && (id_iw == prev_q));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        skip_d  = skip_q && (id_iw == prev_q);
        stall   = 1'b0;
        flush   = 1'b0;
        unique case (state_q)
            RUN: begin
                if (ebrk) begin
                    stall   = 1'b1;
                    state_d = HALT;
                end else if (lu_hit) begin
                    stall = 1'b1;
                    cnt_d = LU_LD;
                    if (LOAD_USE_STALL > 1) state_d = STALL;
                end else if (jump_en) begin
                    flush = 1'b1;
                    if (FLUSH_DEPTH > 0) begin
                        state_d = FLUSH;
                        cnt_d   = FL_LD;
                    end
                end
            end
            STALL: begin
                stall = 1'b1;
                if (cnt_q <= DW'(1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - DW'(1);
                end
            end
            FLUSH: begin
                flush = 1'b1;
                if (cnt_q == '0) state_d = RUN;
                else             cnt_d = cnt_q - DW'(1);
            end
            HALT: begin
                stall = 1'b1;
                if (halt_clr) begin
                    state_d = RUN;
                    skip_d  = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign if_stall  = reset & stall;
    assign id_stall  = reset & stall;
    assign ex_bubble = reset & stall;
    assign if_flush  = reset & flush;
    assign halted    = (state_q == HALT);
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (id_stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (if_flush && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            skip_q      <= 1'b0;
            prev_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            skip_q      <= skip_d;
            prev_q      <= id_iw;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule
